// File: rtl/ysyx_22050019_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050019_div_ctrl_if
//  Brief    : Request/response bus between the divide controller and the
//             iterative 64/64 divider.
//  Revision : 1.0  initial release
// ============================================================================
interface ysyx_22050019_div_ctrl_if;
  logic        div_valid;
  logic [7:0]  div_type_o;
  logic [63:0] dividend_o;
  logic [63:0] divisor_o;
  logic        result_ready;
  logic [63:0] div_out;
  logic        div_stall;
  logic        result_ok;

  // Controller side: issues requests and accepts results
  modport master (
    output div_valid, div_type_o, dividend_o, divisor_o, result_ready,
    input  div_out, div_stall, result_ok
  );

  // Divider side
  modport slave (
    input  div_valid, div_type_o, dividend_o, divisor_o, result_ready,
    output div_out, div_stall, result_ok
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050019_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050019_div_ctrl
//  Brief    : Requester-side controller for the iterative divider. Encodes
//             RV64M div/rem ops into a one-hot type, issues them for a single
//             cycle, collects the result and hands it to writeback. Results
//             of flushed ops are drained since the divider cannot abort.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050019_div_ctrl #(
  parameter int TIMEOUT = 80
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // EXU side
  input  logic                            ex_valid,
  input  logic                            ex_is_div,
  input  logic [2:0]                      funct3,
  input  logic                            is_word,
  input  logic [63:0]                     rs1_data,
  input  logic [63:0]                     rs2_data,
  input  logic [4:0]                      rd_addr,
  input  logic                            flush,
  output logic                            ex_stall,
  // Divider bus
  ysyx_22050019_div_ctrl_if.master        div_if,
  // Writeback side
  output logic                            wb_valid,
  output logic [4:0]                      wb_rd,
  output logic [63:0]                     wb_data,
  input  logic                            wb_ready,
  output logic                            timeout_err
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_RESP  = 3'd4;

  localparam int              c_CW  = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_TMO = c_CW'(TIMEOUT);
  localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

  logic [2:0]      state_q, state_d;
  logic [7:0]      type_q, type_d;
  logic [63:0]     dvd_q, dvd_d;
  logic [63:0]     dvs_q, dvs_d;
  logic [4:0]      rd_q, rd_d;
  logic [63:0]     data_q, data_d;
  logic [c_CW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            w_req;
  logic [7:0]      w_type;
  logic            w_in_wd_q;
  logic            w_in_wd_d;
  logic            w_entry;

  assign w_req = ex_valid & ex_is_div & funct3[2];

  // Map {is_word, funct3[1:0]} onto the divider's one-hot op type
  always_comb begin
    w_type = 8'h00;
    case ({is_word, funct3[1:0]})
      3'b000:  w_type = 8'h80;  // DIV
      3'b001:  w_type = 8'h40;  // DIVU
      3'b010:  w_type = 8'h08;  // REM
      3'b011:  w_type = 8'h04;  // REMU
      3'b100:  w_type = 8'h10;  // DIVW
      3'b101:  w_type = 8'h20;  // DIVUW
      3'b110:  w_type = 8'h01;  // REMW
      3'b111:  w_type = 8'h02;  // REMUW
      default: w_type = 8'h00;
    endcase
  end

  // Next-state, request latching, result capture and timeout tracking
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rd_d    = rd_q;
    data_d  = data_q;

    case (state_q)
      c_IDLE: begin
        if (w_req && !flush) begin
          type_d  = w_type;
          dvd_d   = rs1_data;
          dvs_d   = rs2_data;
          rd_d    = rd_addr;
          state_d = c_ISSUE;
        end
      end
      c_ISSUE: begin
        if (div_if.div_stall) begin
          state_d = flush ? c_DRAIN : c_WAIT;
        end else begin
          // Divide-by-zero / overflow: divider answers in the issue cycle
          data_d  = div_if.div_out;
          state_d = flush ? c_IDLE : c_RESP;
        end
      end
      c_WAIT: begin
        if (div_if.result_ok) begin
          data_d  = div_if.div_out;
          state_d = flush ? c_IDLE : c_RESP;
        end else if (flush) begin
          state_d = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (div_if.result_ok) begin
          state_d = c_IDLE;
        end
      end
      c_RESP: begin
        if (flush || wb_ready) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase

    // Counter restarts whenever WAIT or DRAIN is entered (including WAIT->DRAIN)
    w_in_wd_q = (state_q == c_WAIT) || (state_q == c_DRAIN);
    w_in_wd_d = (state_d == c_WAIT) || (state_d == c_DRAIN);
    w_entry   = w_in_wd_d && (state_d != state_q);

    if (w_entry) begin
      cnt_d = '0;
    end else if (w_in_wd_q && (cnt_q != c_TMO)) begin
      cnt_d = cnt_q + c_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // Sticky; the FSM keeps waiting after the error is flagged
    err_d = err_q | (w_in_wd_d && !w_entry && (cnt_d == c_TMO));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      type_q  <= 8'h00;
      dvd_q   <= 64'd0;
      dvs_q   <= 64'd0;
      rd_q    <= 5'd0;
      data_q  <= 64'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // div_valid only in ISSUE so a returning-to-idle divider never sees a re-issue
  assign div_if.div_valid    = (state_q == c_ISSUE);
  assign div_if.div_type_o   = type_q;
  assign div_if.dividend_o   = dvd_q;
  assign div_if.divisor_o    = dvs_q;
  assign div_if.result_ready = w_in_wd_q & div_if.result_ok;

  assign wb_valid    = (state_q == c_RESP);
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign timeout_err = err_q;

  assign ex_stall = ((state_q == c_IDLE) & w_req)
                  | (state_q == c_ISSUE)
                  | (state_q == c_WAIT)
                  | (state_q == c_DRAIN)
                  | ((state_q == c_RESP) & ~wb_ready);

endmodule
`default_nettype wire

// File: doc/ysyx_22050019_div_ctrl.md
# ysyx_22050019_div_ctrl

Requester-side controller for the iterative 64/64 divider in the NPC execute stage. It accepts RV64M divide/remainder ops from EXU, encodes them into the divider's one-hot type, and issues them with a single-cycle `div_valid`. It then waits for the result, handshakes it out with `result_ready`, and presents it to writeback with valid/ready backpressure. It also drains results after a pipeline flush, because the divider cannot be aborted.

## Interface
- `TIMEOUT`, default 80: max cycles in WAIT/DRAIN before `timeout_err` sets.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ex_valid`  in  1  EXU presents an op this cycle.
- `ex_is_div`  in  1  op is an M-extension op; only honoured when `funct3[2]`=1.
- `funct3`  in  3  100 div, 101 divu, 110 rem, 111 remu.
- `is_word`  in  1  selects the *W variant.
- `rs1_data` / `rs2_data`  in  64  dividend / divisor.
- `rd_addr`  in  5  destination register.
- `flush`  in  1  kill the in-flight op.
- `ex_stall`  out  1  hold EXU.
- `div_valid`  out  1  request to divider.
- `div_type_o`  out  8  one-hot type.
- `dividend_o` / `divisor_o`  out  64  registered operands.
- `result_ready`  out  1  accept divider result.
- `div_out`  in  64  divider result.
- `div_stall`  in  1  divider busy / accepted op for iteration.
- `result_ok`  in  1  divider result valid.
- `wb_valid`  out  1  result to writeback.
- `wb_rd`  out  5  destination.
- `wb_data`  out  64  result.
- `wb_ready`  in  1  writeback accepts.
- `timeout_err`  out  1  sticky, cleared only by reset.

## Operation
- `req` = `ex_valid & ex_is_div & funct3[2]`. A request is accepted only in IDLE. Accepting latches type, operands and `rd_addr`.
- One-hot encoding:
  - DIV 0x80, DIVU 0x40, DIVUW 0x20, DIVW 0x10.
  - REM 0x08, REMU 0x04, REMUW 0x02, REMW 0x01.
- Operands pass unmodified. Sign handling and 32-bit extension are done inside the divider.
- State IDLE: on `req` (no `flush`), latch the request and go to ISSUE.
- State ISSUE: `div_valid`=1, driven from registers.
  - `div_stall`=1: divider accepted the op for iteration. Go to WAIT, or to DRAIN if `flush`.
  - `div_stall`=0: divide-by-zero or overflow. The result is on `div_out` this cycle; capture it into `wb_data` and go to RESP, or to IDLE if `flush`.
- State WAIT:
  - `result_ready` = `result_ok`, combinational.
  - On `result_ok`, capture `div_out` and go to RESP (IDLE if `flush` in the same cycle).
  - `flush` without `result_ok` goes to DRAIN.
- State DRAIN: `result_ready` = `result_ok`. On `result_ok`, discard the result and go to IDLE. `flush` is ignored here.
- State RESP: `wb_valid`=1; `wb_rd` and `wb_data` stay stable.
  - `wb_ready` goes to IDLE.
  - `flush` goes to IDLE with no handshake; `flush` takes priority over `wb_ready`.
- `div_valid` is never high outside ISSUE. This prevents re-issue when the divider returns to IDLE.
- `ex_stall` = (IDLE & `req`) | ISSUE | WAIT | DRAIN | (RESP & ~`wb_ready`).
- Timeout counter:
  - Clears on entry to WAIT/DRAIN and increments each cycle there.
  - Reaching `TIMEOUT` sets `timeout_err`. The FSM keeps waiting.

## Timing
- Reset, checked at `posedge clk` with `rst_n`=0:
  - State goes to IDLE.
  - All outputs are 0: `div_valid`, `div_type_o`, operands, `result_ready`, `wb_valid`, `wb_rd`, `wb_data`, `timeout_err`.
  - `ex_stall` is 0 unless the combinational `req` term is active.
- Reset mid-operation: the divider shares `rst_n`, so both blocks return to IDLE with no stale result.
- Normal latency:
  - Accept at cycle 0, ISSUE at cycle 1.
  - Divider `result_ok` arrives about 66 cycles after ISSUE for 64-bit ops and about 34 for *W ops. The block must not depend on the exact count.
  - `wb_valid` asserts the cycle after `result_ok`.
- Exception latency: `wb_valid` at cycle 2, i.e. the cycle after ISSUE.
- `result_ready` is high only in a cycle where `result_ok` is high and the state is WAIT or DRAIN. It is a single-cycle pulse.
- Back-to-back: a new request can be accepted in the cycle after the RESP handshake. The earliest next ISSUE is 2 cycles after `wb_valid & wb_ready`.

## Test plan
- DIV, `rs1`=100, `rs2`=7, `rd`=5:
  - ISSUE shows `div_type_o`=0x80.
  - One `result_ready` pulse.
  - `wb_data`=14, `wb_rd`=5.
  - `ex_stall` is high from accept until the handshake.
- REMW, `rs1`=0xFFFFFFFFFFFFFFF9, `rs2`=2: `div_type_o`=0x01, `wb_data`=0xFFFFFFFFFFFFFFFF.
- DIVU, `rs2`=0: `div_stall` stays 0 in ISSUE. No WAIT and no `result_ready`. `wb_valid` at cycle 2 with `wb_data`=0xFFFFFFFFFFFFFFFF.
- DIV, `rs1`=0x8000000000000000, `rs2`=0xFFFFFFFFFFFFFFFF: exception path, `wb_data`=0x8000000000000000.
- `flush` 10 cycles into WAIT:
  - Goes to DRAIN; `result_ready` pulses exactly with `result_ok`.
  - No `wb_valid`.
  - A following DIVU 9/2 returns 4.
- `wb_ready` held low for 3 cycles in RESP: `wb_valid`, `wb_rd`, `wb_data` and `ex_stall` stay stable. Separately, a divider model that withholds `result_ok` makes `timeout_err` rise exactly 80 cycles after WAIT entry.
